fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Multi-cycle control FSM that sequences the 16-bit program counter and instruction fetch.
//  Drives the PC increment/load controls and issues req/ack reads to instruction memory.
//  Latches the instruction register and hands it to the execute unit.
//  Tracks retired instructions and flags fetch timeouts; sits between the PC, imem and execute.
// PARAMETERS
//  ADDR_W    16  PC / memory address width
//  INSTR_W   16  instruction width
//  WAIT_MAX  15  max cycles in FETCH without mem_ack before FAULT (1..255)
// PORTS
//  clk            in   1        single clock, all state updates on posedge
//  reset          in   1        synchronous, active-high
//  run            in   1        level; start/resume from IDLE or HALTED
//  halt_req       in   1        one-cycle or level request to stop at next instruction boundary
//  pc_q           in   ADDR_W   current PC value
//  pc_increment   out  1        one-cycle pulse; PC += 1 on the following edge
//  pc_load        out  1        one-cycle pulse; PC <= pc_load_val on the following edge
//  pc_load_val    out  ADDR_W   branch target, valid while pc_load=1
//  mem_req        out  1        imem read request
//  mem_addr       out  ADDR_W   = pc_q while mem_req=1, else 0
//  mem_ack        in   1        imem read complete; mem_rdata valid same cycle
//  mem_rdata      in   INSTR_W  fetched instruction
//  ir             out  INSTR_W  instruction register
//  ir_valid       out  1        high throughout EXEC
//  exec_done      in   1        execute unit finished current ir
//  branch_taken   in   1        sampled with exec_done
//  branch_target  in   ADDR_W   sampled with exec_done
//  busy           out  1        state is FETCH, EXEC or UPDATE
//  halted         out  1        state is HALTED
//  fault          out  1        state is FAULT (sticky until reset)
//  retired        out  16       retired-instruction count; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: state=IDLE; ir=0, retired=0, halt_pend=0, wait_cnt=0; all outputs 0.
//  States:
//   IDLE   : run=1 -> FETCH.
//   FETCH  : mem_req=1. mem_ack=1 -> ir<=mem_rdata, wait_cnt<=0, -> EXEC (ack may arrive the first FETCH cycle).
//            Else wait_cnt++; wait_cnt==WAIT_MAX-1 with no ack -> FAULT.
//   EXEC   : ir_valid=1. exec_done=1 -> latch branch_taken and branch_target, -> UPDATE.
//   UPDATE : exactly one cycle.
//            Taken branch: pc_load=1, pc_load_val=target. Otherwise pc_increment=1.
//            retired++. Then halt_pend|halt_req -> HALTED (clear halt_pend); else -> FETCH.
//   HALTED : run=1 -> FETCH; halt_req is ignored here.
//   FAULT  : terminal; only reset exits.
//  halt_req seen in FETCH/EXEC sets halt_pend; the current instruction always completes.
//  halt_req in IDLE is ignored.
//  PC timing: the PC updates on the edge that ends UPDATE, so the next FETCH presents the new pc_q.
//  Minimum loop is 3 cycles per instruction (FETCH, EXEC, UPDATE) with ack and exec_done immediate.
//  pc_increment and pc_load are never high together; never high outside UPDATE.
//  exec_done outside EXEC and mem_ack outside FETCH are ignored.
//  Reset mid-operation: reset wins over every transition; outputs are 0 the cycle after the reset edge.
// TESTING
//  1. Reset, then run=1, pc_q=0x0000, ack and exec_done immediate.
//     -> mem_req at cycles 1,4,7; pc_increment at cycles 3,6,9; retired=3 after 9 cycles.
//  2. Fetch returns 0xA5C3, exec_done with branch_taken=1, target=0x1234.
//     -> ir=0xA5C3; pc_load=1 for 1 cycle, pc_load_val=0x1234; pc_increment stays 0.
//  3. mem_ack withheld, WAIT_MAX=15.
//     -> fault=1 after 15 FETCH cycles; mem_req=0 afterwards; late ack ignored; reset clears.
//  4. halt_req pulse mid-EXEC.
//     -> instruction completes (one pc_increment), halted=1, no further mem_req.
//     -> run=1 resumes FETCH at the incremented pc_q.
//  5. Preload-free wrap: run 65536 instructions.
//     -> retired wraps to 0x0000; pc_q 0xFFFF -> 0x0000 fetched at addr 0x0000.
//  6. Assert reset during EXEC with exec_done=1 same cycle.
//     -> next cycle IDLE; ir=0; no pc_increment/pc_load pulse; retired=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequence controller: walks FETCH -> EXEC -> UPDATE per instruction,
// drives PC increment/load, handles halt requests and fetch timeouts.
module fetch_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int INSTR_W  = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_run,
    input  logic               i_halt_req,
    input  logic [ADDR_W-1:0]  i_pc_q,
    output logic               o_pc_increment,
    output logic               o_pc_load,
    output logic [ADDR_W-1:0]  o_pc_load_val,
    output logic               o_mem_req,
    output logic [ADDR_W-1:0]  o_mem_addr,
    input  logic               i_mem_ack,
    input  logic [INSTR_W-1:0] i_mem_rdata,
    output logic [INSTR_W-1:0] o_ir,
    output logic               o_ir_valid,
    input  logic               i_exec_done,
    input  logic               i_branch_taken,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_busy,
    output logic               o_halted,
    output logic               o_fault,
    output logic [15:0]        o_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_UPDATE = 3'd3,
        S_HALTED = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_next;
    logic [7:0]          r_wait_cnt;
    logic                r_halt_pend;
    logic                r_br_taken;
    logic [ADDR_W-1:0]   r_br_target;
    logic [INSTR_W-1:0]  r_ir;
    logic [15:0]         r_retired;
    logic                w_halt_now;

    assign w_halt_now = r_halt_pend | i_halt_req;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_halt_pend <= 1'b0;
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
            r_ir        <= '0;
            r_retired   <= 16'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_FETCH: begin
                    r_halt_pend <= w_halt_now;
                    if (i_mem_ack) begin
                        r_ir       <= i_mem_rdata;
                        r_wait_cnt <= 8'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    r_halt_pend <= w_halt_now;
                    if (i_exec_done) begin
                        r_br_taken  <= i_branch_taken;
                        r_br_target <= i_branch_target;
                    end
                end
                S_UPDATE: begin
                    // Pending halt is consumed here whether or not we stop.
                    r_retired   <= r_retired + 16'd1;
                    r_halt_pend <= 1'b0;
                    r_wait_cnt  <= 8'd0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        o_pc_increment = 1'b0;
        o_pc_load      = 1'b0;
        o_pc_load_val  = '0;
        o_mem_req      = 1'b0;
        o_mem_addr     = '0;
        o_ir_valid     = 1'b0;
        o_busy         = 1'b0;
        o_halted       = 1'b0;
        o_fault        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) w_next = S_FETCH;
            end
            S_FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = i_pc_q;
                o_busy     = 1'b1;
                if (i_mem_ack)                    w_next = S_EXEC;
                else if (r_wait_cnt == WAIT_LAST) w_next = S_FAULT;
            end
            S_EXEC: begin
                o_ir_valid = 1'b1;
                o_busy     = 1'b1;
                if (i_exec_done) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                o_busy = 1'b1;
                if (r_br_taken) begin
                    o_pc_load     = 1'b1;
                    o_pc_load_val = r_br_target;
                end else begin
                    o_pc_increment = 1'b1;
                end
                w_next = w_halt_now ? S_HALTED : S_FETCH;
            end
            S_HALTED: begin
                o_halted = 1'b1;
                if (i_run) w_next = S_FETCH;
            end
            S_FAULT: begin
                o_fault = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_ir      = r_ir;
    assign o_retired = r_retired;

endmodule
